alu_ex_stage: RTL and testbench

ALU_EX_STAGE -- requirements
Module: alu_ex_stage

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_core.sv | 57 +++++
 rtl/alu_ex_stage.sv | 109 ++++++++++
 tb/tb_alu_ex_stage.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU operation codes, used by the ALU control block and the execute stage.
package alu_pkg;

    localparam logic [4:0] ALU_AND = 5'b00000;
    localparam logic [4:0] ALU_OR  = 5'b00001;
    localparam logic [4:0] ALU_ADD = 5'b00010;
    localparam logic [4:0] ALU_SUB = 5'b00110;
    localparam logic [4:0] ALU_SLT = 5'b00111;
    localparam logic [4:0] ALU_NOR = 5'b01100;
    localparam logic [4:0] ALU_XOR = 5'b01101;
    localparam logic [4:0] ALU_SLL = 5'b10000;
    localparam logic [4:0] ALU_SRL = 5'b11000;
    localparam logic [4:0] ALU_SRA = 5'b11001;

    localparam int unsigned FIFO_DEPTH = 2;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath. The ovf port exists only when ALU_OVERFLOW_DETECT_EN is defined.
module alu_core
    import alu_pkg::*;
(
    input  logic [4:0]  ctl,
    input  logic        sign,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  shamt,
    output logic [31:0] result
`ifdef ALU_OVERFLOW_DETECT_EN
    ,
    output logic        ovf
`endif
);

    logic [31:0] sum;
    logic [31:0] diff;
    logic        lt;

    assign sum  = a + b;
    assign diff = a - b;
    assign lt   = sign ? ($signed(a) < $signed(b)) : (a < b);

    always_comb begin
        result = sum;
        case (ctl)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = sum;
            ALU_SUB: result = diff;
            ALU_SLT: result = {31'd0, lt};
            ALU_NOR: result = ~(a | b);
            ALU_XOR: result = a ^ b;
            ALU_SLL: result = b << shamt;
            ALU_SRL: result = b >> shamt;
            ALU_SRA: result = $unsigned($signed(b) >>> shamt);
            default: result = sum;
        endcase
    end

`ifdef ALU_OVERFLOW_DETECT_EN
    // Unknown codes execute ADD, so they flag ADD overflow as well.
    always_comb begin
        ovf = 1'b0;
        if (sign) begin
            case (ctl)
                ALU_SUB: ovf = (a[31] != b[31]) && (diff[31] != a[31]);
                ALU_AND, ALU_OR, ALU_SLT, ALU_NOR, ALU_XOR,
                ALU_SLL, ALU_SRL, ALU_SRA: ovf = 1'b0;
                default: ovf = (a[31] == b[31]) && (sum[31] != a[31]);
            endcase
        end
    end
`endif

endmodule

// File: rtl/alu_ex_stage.sv
// ALU execute stage: alu_core feeding a 2-entry result FIFO with valid/ready handshakes.
// Define ALU_OVERFLOW_DETECT_EN to store and report signed ADD/SUB overflow per entry.
module alu_ex_stage
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  alu_ctl,
    input  logic        sign,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [4:0]  shamt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_zero,
    output logic        out_ovf
);

    logic [31:0] core_res;
    logic [31:0] res_q [FIFO_DEPTH];
    logic [1:0]  count_q, count_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        push, pop;

`ifdef ALU_OVERFLOW_DETECT_EN
    logic        core_ovf;
    logic        ovf_q [FIFO_DEPTH];
`endif

    alu_core u_core (
        .ctl    (alu_ctl),
        .sign   (sign),
        .a      (op_a),
        .b      (op_b),
        .shamt  (shamt),
        .result (core_res)
`ifdef ALU_OVERFLOW_DETECT_EN
        ,
        .ovf    (core_ovf)
`endif
    );

    assign in_ready  = (count_q < 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = ~wr_ptr_q;
            if (pop)  rd_ptr_d = ~rd_ptr_q;
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                res_q[i] <= '0;
`ifdef ALU_OVERFLOW_DETECT_EN
                ovf_q[i] <= 1'b0;
`endif
            end
        end else if (push && !flush) begin
            res_q[wr_ptr_q] <= core_res;
`ifdef ALU_OVERFLOW_DETECT_EN
            ovf_q[wr_ptr_q] <= core_ovf;
`endif
        end
    end

    // Outputs are gated by out_valid so stale entries never show after a flush.
    assign out_result = out_valid ? res_q[rd_ptr_q] : 32'd0;
    assign out_zero   = out_valid && (res_q[rd_ptr_q] == 32'd0);
`ifdef ALU_OVERFLOW_DETECT_EN
    assign out_ovf    = out_valid && ovf_q[rd_ptr_q];
`else
    assign out_ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ex_stage.sv
// Directed bench for alu_ex_stage; expected overflow follows ALU_OVERFLOW_DETECT_EN.
module tb_alu_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, sign, out_valid, out_ready;
    logic        out_zero, out_ovf;
    logic [4:0]  alu_ctl, shamt;
    logic [31:0] op_a, op_b, out_result;

    int total = 0;
    int bad   = 0;

`ifdef ALU_OVERFLOW_DETECT_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    alu_ex_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_ctl    (alu_ctl),
        .sign       (sign),
        .op_a       (op_a),
        .op_b       (op_b),
        .shamt      (shamt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_ovf    (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] c, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh);
        alu_ctl = c; sign = s; op_a = a; op_b = b; shamt = sh;
    endtask

    // Push one op, check the head next cycle, then pop it.
    task automatic one(input string tag, input logic [4:0] c, input logic s,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                       input logic [31:0] exp_res, input logic exp_ovf);
        drive(c, s, a, b, sh);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk({tag, ".vld"}, {31'd0, out_valid}, 32'd1);
        chk({tag, ".res"}, out_result, exp_res);
        chk({tag, ".zero"}, {31'd0, out_zero}, {31'd0, exp_res == 32'd0});
        chk({tag, ".ovf"}, {31'd0, out_ovf}, {31'd0, exp_ovf});
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, ".empty"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive(5'd0, 1'b0, 32'd0, 32'd0, 5'd0);
        #3;
        chk("rst.vld",  {31'd0, out_valid}, 32'd0);
        chk("rst.rdy",  {31'd0, in_ready},  32'd1);
        chk("rst.res",  out_result,         32'd0);
        chk("rst.zero", {31'd0, out_zero},  32'd0);
        chk("rst.ovf",  {31'd0, out_ovf},   32'd0);
        #10 rst_n = 1'b1;
        step();

        one("add_ovf",  5'b00010, 1'b1, 32'h7FFFFFFF, 32'd1, 5'd0, 32'h80000000, OVF_ON);
        one("add_uns",  5'b00010, 1'b0, 32'h7FFFFFFF, 32'd1, 5'd0, 32'h80000000, 1'b0);
        one("sub_ovf",  5'b00110, 1'b1, 32'h80000000, 32'd1, 5'd0, 32'h7FFFFFFF, OVF_ON);
        one("slt_s",    5'b00111, 1'b1, 32'hFFFFFFFF, 32'd1, 5'd0, 32'd1, 1'b0);
        one("slt_u",    5'b00111, 1'b0, 32'hFFFFFFFF, 32'd1, 5'd0, 32'd0, 1'b0);
        one("sra",      5'b11001, 1'b0, 32'd0, 32'h80000000, 5'd4, 32'hF8000000, 1'b0);
        one("srl",      5'b11000, 1'b0, 32'd0, 32'h80000000, 5'd4, 32'h08000000, 1'b0);
        one("sll",      5'b10000, 1'b0, 32'd0, 32'h00000003, 5'd31, 32'h80000000, 1'b0);
        one("and",      5'b00000, 1'b0, 32'hF0F0FFFF, 32'h0FF0F00F, 5'd0, 32'h00F0F00F, 1'b0);
        one("nor",      5'b01100, 1'b0, 32'hF0F00000, 32'h0000000F, 5'd0, 32'h0F0FFFF0, 1'b0);
        one("undef",    5'b11111, 1'b0, 32'd3, 32'd4, 5'd0, 32'd7, 1'b0);

        // Fill both entries with the consumer stalled; third push must be dropped.
        out_ready = 1'b0;
        drive(5'b00110, 1'b0, 32'd5, 32'd5, 5'd0);
        in_valid = 1'b1;
        step();
        chk("full.rdy1", {31'd0, in_ready}, 32'd1);
        drive(5'b00001, 1'b0, 32'd1, 32'd2, 5'd0);
        step();
        chk("full.rdy2", {31'd0, in_ready}, 32'd0);
        drive(5'b01101, 1'b0, 32'd3, 32'd3, 5'd0);
        step();
        chk("full.rdy3", {31'd0, in_ready}, 32'd0);
        chk("full.hold", out_result, 32'd0);
        chk("full.hz",   {31'd0, out_zero}, 32'd1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk("full.v2",   {31'd0, out_valid}, 32'd1);
        chk("full.r2",   out_result, 32'd3);
        chk("full.z2",   {31'd0, out_zero}, 32'd0);
        step();
        chk("full.drop", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;

        // Steady state at count=1 with push and pop every cycle.
        drive(5'b00010, 1'b0, 32'h100, 32'd0, 5'd0);
        in_valid = 1'b1;
        step();
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            op_b = i;
            chk($sformatf("pp.res%0d", i), out_result, 32'h100 + i - 1);
            chk($sformatf("pp.rdy%0d", i), {31'd0, in_ready}, 32'd1);
            step();
        end
        in_valid = 1'b0;
        chk("pp.last", out_result, 32'h104);
        step();
        chk("pp.empty", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;

        // Flush with a full FIFO and a pending push.
        drive(5'b00010, 1'b0, 32'd10, 32'd1, 5'd0);
        in_valid = 1'b1;
        step();
        step();
        chk("fl.full", {31'd0, in_ready}, 32'd0);
        flush = 1'b1;
        out_ready = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl.vld", {31'd0, out_valid}, 32'd0);
        chk("fl.rdy", {31'd0, in_ready},  32'd1);
        step();
        chk("fl.none", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;
        one("fl.after", 5'b01101, 1'b0, 32'hA5A5A5A5, 32'hFFFF0000, 5'd0, 32'h5A5AA5A5, 1'b0);

        // Asynchronous reset in the middle of a cycle with data buffered.
        drive(5'b00001, 1'b0, 32'd8, 32'd1, 5'd0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("ar.vld", {31'd0, out_valid}, 32'd0);
        chk("ar.res", out_result, 32'd0);
        chk("ar.rdy", {31'd0, in_ready}, 32'd1);
        step();
        rst_n = 1'b1;
        step();
        chk("ar.idle", {31'd0, out_valid}, 32'd0);
        one("ar.after", 5'b00010, 1'b0, 32'd20, 32'd22, 5'd0, 32'd42, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
